// File: rtl/cnt_snapshot_tx.sv
// cnt_snapshot_tx: latches the live event count and streams it MSB-first as bytes; SNAP_HEADER_EN adds an 0xA5 header byte
module cnt_snapshot_tx #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             snap,
  output logic             busy,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             done,
  output logic             overrun
);
  localparam int NBYTES = CNT_W / 8;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
`ifdef SNAP_HEADER_EN
  typedef enum logic [1:0] {IDLE, SEND, HDR} state_t;
  localparam state_t FIRST = HDR;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
  localparam state_t FIRST = SEND;
`endif
  state_t st, nxt;
  logic [CNT_W-1:0] shadow;
  logic [IW-1:0] idx;
  logic done_q, ovr_q;
  logic hs, accept, last_hs;
  assign hs = tx_valid & tx_ready;
  assign accept = (st == IDLE) & snap;
  assign last_hs = (st == SEND) & hs & (idx == '0);
  assign tx_valid = st != IDLE;
  assign busy = tx_valid;
  assign done = done_q;
  assign overrun = ovr_q;
`ifdef SNAP_HEADER_EN
  assign tx_data = (st == HDR) ? 8'hA5 : (st == SEND) ? shadow[{idx, 3'b000} +: 8] : 8'h00;
`else
  assign tx_data = (st == SEND) ? shadow[{idx, 3'b000} +: 8] : 8'h00;
`endif
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= nxt;
  // next state: accept in IDLE, leave SEND after the final byte handshake
  always_comb begin
    nxt = st;
    if (st == IDLE) nxt = snap ? FIRST : IDLE;
`ifdef SNAP_HEADER_EN
    else if (st == HDR) nxt = hs ? SEND : HDR;
`endif
    else nxt = last_hs ? IDLE : SEND;
  end
  // shadow capture, byte index walk, done pulse and sticky overrun
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      shadow <= '0;
      idx <= '0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      shadow <= accept ? cnt_in : shadow;
      idx <= accept ? LAST : ((st == SEND) && hs && (idx != '0)) ? idx - 1'b1 : idx;
      done_q <= last_hs;
      ovr_q <= ovr_q | (snap & (st != IDLE));
    end
endmodule

// File: tb/tb_cnt_snapshot_tx.sv
// tb_cnt_snapshot_tx: table-driven check of snapshot capture, byte streaming, done, overrun and async reset
module tb_cnt_snapshot_tx;
  logic clk, rst, snap, tx_ready, busy, tx_valid, done, overrun;
  logic [63:0] cnt_in;
  logic [7:0] tx_data;
  int checks = 0;
  int errors = 0;
  logic ovr = 1'b0;
  typedef struct {
    logic snap;
    logic rdy;
    logic [63:0] cnt;
    logic act;
    logic [7:0] data;
    logic done;
    logic ovr;
  } vec_t;
  vec_t tbl[$];

  cnt_snapshot_tx #(.CNT_W(64)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .snap(snap), .busy(busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .done(done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic outs(input int id, input logic act, input logic [7:0] data, input logic dn, input logic ov);
    chk("tx_valid", id, 64'(tx_valid), 64'(act));
    chk("busy", id, 64'(busy), 64'(act));
    chk("tx_data", id, 64'(tx_data), 64'(data));
    chk("done", id, 64'(done), 64'(dn));
    chk("overrun", id, 64'(overrun), 64'(ov));
  endtask

  task automatic add(input logic s, input logic r, input logic [63:0] c, input logic a,
                     input logic [7:0] d, input logic dn, input logic ov);
    vec_t v;
    v.snap = s; v.rdy = r; v.cnt = c; v.act = a; v.data = d; v.done = dn; v.ovr = ov;
    tbl.push_back(v);
  endtask

  // accept cycle plus every offered byte; tog inserts a ready=0 cycle before each later byte
  task automatic frame(input logic [63:0] val, input bit tog, input int snap_at, input bit hold, input bit after_done);
    logic [7:0] it[$];
    logic s;
    it = {};
`ifdef SNAP_HEADER_EN
    it.push_back(8'hA5);
`endif
    for (int k = 0; k < 8; k++) it.push_back(val[8*(7-k) +: 8]);
    add(1'b1, 1'b1, val, 1'b0, 8'h00, after_done, ovr);
    for (int k = 0; k < it.size(); k++) begin
      if (tog && k > 0) begin
        s = hold;
        add(s, 1'b0, val + 64'(2*k), 1'b1, it[k], 1'b0, ovr);
        if (s) ovr = 1'b1;
      end
      s = hold || (k == snap_at);
      add(s, 1'b1, val + 64'(2*k+1), 1'b1, it[k], 1'b0, ovr);
      if (s) ovr = 1'b1;
    end
  endtask

  task automatic done_idle();
    add(1'b0, 1'b1, 64'h0, 1'b0, 8'h00, 1'b1, ovr);
    add(1'b0, 1'b1, 64'h0, 1'b0, 8'h00, 1'b0, ovr);
  endtask

  initial begin
    int pre;
`ifdef SNAP_HEADER_EN
    pre = 1;
`else
    pre = 0;
`endif
    rst = 1'b1; snap = 1'b0; tx_ready = 1'b0; cnt_in = 64'h0;
    #1 rst = 1'b0;
    #1 outs(-1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;

    frame(64'h0123456789ABCDEF, 1'b0, -1, 1'b0, 1'b0); done_idle();
    frame(64'h0123456789ABCDEF, 1'b1, -1, 1'b0, 1'b0); done_idle();
    frame(64'h1122334455667788, 1'b0, 3, 1'b0, 1'b0); done_idle();
    frame(64'hFFFFFFFFFFFFFFFF, 1'b0, -1, 1'b0, 1'b0); done_idle();
    frame(64'hDEADBEEF00C0FFEE, 1'b0, -1, 1'b1, 1'b0);
    frame(64'h0F1E2D3C4B5A6978, 1'b0, -1, 1'b1, 1'b1);
    done_idle();

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      outs(i, tbl[i].act, tbl[i].data, tbl[i].done, tbl[i].ovr);
      snap = tbl[i].snap; tx_ready = tbl[i].rdy; cnt_in = tbl[i].cnt;
    end

    @(negedge clk);
    snap = 1'b1; tx_ready = 1'b0; cnt_in = 64'h8877665544332211;
    @(negedge clk);
    snap = 1'b0; tx_ready = 1'b1;
    repeat (pre + 4) @(negedge clk);
    tx_ready = 1'b0;
    outs(1000, 1'b1, 8'h44, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1 outs(1001, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    outs(1002, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1; tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outs(1003 + i, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    snap = 1'b1; cnt_in = 64'h5500000000000000;
    @(negedge clk);
    snap = 1'b0;
    outs(1006, 1'b1, (pre == 1) ? 8'hA5 : 8'h55, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cnt_snapshot_tx.md
Name: cnt_snapshot_tx

Overview:
Readout side of the hit counter used in threshold scans.
- On a snapshot request, latches the free-running 64-bit event count into a shadow register.
- Streams the latched value out as bytes, MSB first, over a valid/ready byte interface to the link/UART framer.
- Decouples counter sampling from the link rate, so counting never stalls during readout.

Parameters:
CNT_W, 64, counter width in bits; must be a multiple of 8 and at least 8.
NBYTES, CNT_W/8, payload bytes per snapshot (derived; not overridden).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
cnt_in  input  CNT_W  live count from the hit counter; synchronous to clk.
snap  input  1  snapshot request, sampled each cycle.
busy  output  1  high from the cycle after snapshot acceptance until the last byte handshake.
tx_data  output  8  byte being offered.
tx_valid  output  1  tx_data valid.
tx_ready  input  1  downstream accepts the byte when high together with tx_valid.
done  output  1  one-cycle pulse after the final byte is accepted.
overrun  output  1  sticky; a snap was dropped because a transfer was in progress.

Behaviour:
Reset (rst=0, async):
- State IDLE; shadow register=0; byte index=0.
- busy=0, tx_valid=0, tx_data=0, done=0, overrun=0.

States: IDLE, SEND (plus HDR with the optional feature).

IDLE:
- snap=1 at edge N: shadow<=cnt_in value at edge N; index<=NBYTES-1; state<=SEND.
- At N+1: busy=1, tx_valid=1, tx_data=shadow[CNT_W-1:CNT_W-8].
- Latency from snap to first valid byte is 1 cycle.

SEND:
- tx_data = shadow byte at index (index NBYTES-1 = most significant byte).
- tx_valid=1 continuously.
- tx_data is stable while tx_valid=1 and tx_ready=0.
- Handshake (tx_valid&tx_ready) with index>0: index decrements; the next byte appears in the next cycle. This gives back-to-back bytes at 1 byte/cycle when tx_ready is held high.
- Handshake with index=0: state<=IDLE. The next cycle has tx_valid=0, busy=0, done=1 for exactly one cycle, tx_data=0.

Snap during a transfer:
- snap=1 while state is not IDLE is ignored; the shadow is unchanged and overrun<=1.
- overrun is cleared only by reset.

Snap in the done cycle:
- Accepted (state is IDLE): the new transfer starts.
- done and the new busy overlap: at that edge busy goes high and done falls.

Other rules:
- Shadow is written only on snap acceptance in IDLE. cnt_in changes during SEND never affect transmitted bytes.
- Counter wrap-around is transparent: the shadow carries the raw value, e.g. all-ones is sent as NBYTES bytes of 0xFF.
- Reset mid-transfer: immediate return to IDLE with reset values; the partial frame is abandoned, never resumed.
- tx_ready is ignored when tx_valid=0.

Optional Feature:
Macro: SNAP_HEADER_EN.
- Defined:
  - Accepting a snap enters HDR, which offers tx_data=0xA5 with tx_valid=1.
  - The 0xA5 handshake moves to SEND at index NBYTES-1.
  - A frame is NBYTES+1 bytes; the first payload byte arrives 1 cycle after the header handshake.
  - HDR counts as busy for overrun purposes.
- Not defined: the HDR state is absent; a frame is exactly NBYTES bytes, as above.

Test Plan:
1. Reset, CNT_W=64, cnt_in=0x0123456789ABCDEF, snap pulse, tx_ready=1 -> bytes 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles starting 1 cycle after snap; done pulse 1 cycle after the EF handshake; overrun=0.
2. Same snapshot with tx_ready toggling 1/0 each cycle, and cnt_in incrementing every cycle -> identical 8-byte sequence; tx_data held during ready=0 cycles; 15 cycles from first valid to last handshake.
3. snap asserted again during byte 3 -> transfer unaffected, overrun=1 and stays 1 through a later clean transfer, until rst=0.
4. snap held high continuously, tx_ready=1 -> back-to-back frames with one IDLE/done cycle between them; each frame carries the cnt_in value sampled at its acceptance edge.
5. rst=0 asserted while byte 5 is pending -> tx_valid, busy, done, tx_data and overrun all 0 immediately (async); after release, no output until the next snap.
6. SNAP_HEADER_EN defined, cnt_in=0xFFFFFFFFFFFFFFFF -> frame A5 then 8×FF; 9 handshakes before done.
